handshake_io_buffer: RTL
========================

HANDSHAKE_IO_BUFFER -- requirements
Module: handshake_io_buffer

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits on both channels; legal range 1..32.
REQ-002 Parameter DEPTH, default 4, entries per FIFO (RX and TX each); power of 2, minimum 2.
REQ-003 Derived constant CW = log2(DEPTH)+1, occupancy counter width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in  input  WIDTH  data word from external producer.
REQ-007 inDataReady  input  1  producer request, 4-phase.
REQ-008 inACK  output  1  acknowledge to producer, registered.
REQ-009 out  output  WIDTH  data word to external consumer, registered.
REQ-010 outDataReady  output  1  request to consumer, registered.
REQ-011 outACK  input  1  consumer acknowledge, 4-phase.
REQ-012 rxData  output  WIDTH  RX FIFO head, first-word-fall-through.
REQ-013 rxRead  input  1  processor pops RX head.
REQ-014 rxEmpty  output  1  RX FIFO empty; rxCount  output  CW  RX occupancy.
REQ-015 txData  input  WIDTH  word from processor; txWrite  input  1  push txData.
REQ-016 txFull  output  1  TX FIFO full; txCount  output  CW  TX occupancy.
REQ-017 All external inputs are synchronous to clk; no synchronizers in this block.

Function
REQ-018 RX FSM states RX_IDLE, RX_ACK; TX FSM states TX_IDLE, TX_SEND, TX_WAIT.
REQ-019 RX_IDLE: inDataReady=1 and rxCount<DEPTH at an edge -> store in, inACK=1, go RX_ACK, all on that edge.
REQ-020 RX_IDLE with RX FIFO full: no store, inACK stays 0 (backpressure) until space exists.
REQ-021 RX_ACK: inACK held 1 while inDataReady=1; inDataReady=0 at an edge -> inACK=0, RX_IDLE on that edge.
REQ-022 Full test uses registered rxCount; a same-cycle rxRead does not enable a store to a full FIFO.
REQ-023 rxRead=1 with rxEmpty=0 pops one word; rxRead with rxEmpty=1 is ignored, no state change.
REQ-024 Simultaneous RX store and pop: both occur, rxCount unchanged; store into empty FIFO with pop is impossible (pop ignored).
REQ-025 txWrite=1 with txFull=0 pushes txData; txWrite with txFull=1 ignored, word dropped.
REQ-026 TX_IDLE: txCount>0 and outACK=0 at an edge -> pop head into out, outDataReady=1, go TX_SEND.
REQ-027 TX_SEND: out and outDataReady held; outACK=1 at an edge -> outDataReady=0, go TX_WAIT.
REQ-028 TX_WAIT: outACK=0 at an edge -> TX_IDLE; out keeps last sent value.
REQ-029 Simultaneous txWrite push and TX_IDLE pop: both occur, txCount unchanged.
REQ-030 Latency: RX word visible on rxData/rxEmpty=0 after the capture edge; TX word on out one edge after the push edge when TX_IDLE and outACK=0.
REQ-031 FIFO pointers wrap modulo DEPTH; counts span 0..DEPTH; rxEmpty=(rxCount==0), txFull=(txCount==DEPTH).

Reset
REQ-032 reset=0 immediately forces inACK=0, outDataReady=0, out=0, both FIFOs empty (counts 0, pointers 0), FSMs to RX_IDLE/TX_IDLE.
REQ-033 Reset mid-handshake discards all buffered and in-flight words; no handshake resumes after release.
REQ-034 First state change possible on the first rising edge with reset=1.

Verification
REQ-035 Single RX: in=8'hA5, inDataReady=1 -> inACK=1 next edge, rxData=8'hA5, rxCount=1; drop inDataReady -> inACK=0 next edge.
REQ-036 RX full, DEPTH=4: five producer transfers without rxRead -> four acked, fifth inACK=0 until one rxRead, then acked.
REQ-037 TX burst: txWrite 8'h01,8'h02,8'h03 back-to-back, consumer 4-phase with 2-cycle ack delay -> out sequence 01,02,03, outDataReady low between words.
REQ-038 TX overflow: five txWrite with outACK forced 1 -> txFull after four, fifth word never appears on out.
REQ-039 Reset mid-operation: reset=0 during TX_SEND with txCount=2 -> outDataReady=0, out=0, txCount=0 immediately; no output after release.
REQ-040 WIDTH=16, DEPTH=8 build: loopback rxData->txData over 8 words -> out matches in order, pointers wrap correctly.

Source files
------------

// File: rtl/handshake_io_buffer_if.sv
// Signal bundle for handshake_io_buffer: 4-phase producer/consumer channels
// plus the processor-side RX pop and TX push ports.
interface handshake_io_buffer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in;
  logic             inDataReady;
  logic             inACK;
  logic [WIDTH-1:0] out;
  logic             outDataReady;
  logic             outACK;

  logic [WIDTH-1:0] rxData;
  logic             rxRead;
  logic             rxEmpty;
  logic [CW-1:0]    rxCount;
  logic [WIDTH-1:0] txData;
  logic             txWrite;
  logic             txFull;
  logic [CW-1:0]    txCount;

  modport slave (
    input  in, inDataReady, outACK, rxRead, txData, txWrite,
    output inACK, out, outDataReady, rxData, rxEmpty, rxCount, txFull, txCount
  );

  modport master (
    output in, inDataReady, outACK, rxRead, txData, txWrite,
    input  inACK, out, outDataReady, rxData, rxEmpty, rxCount, txFull, txCount
  );
endinterface

// File: rtl/handshake_io_buffer.sv
// Bridges a 4-phase producer and a 4-phase consumer to a processor through
// an RX FIFO (first-word-fall-through) and a TX FIFO.
module handshake_io_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  handshake_io_buffer_if.slave  bus,
  output logic                  rx_state,
  output logic [1:0]            tx_state
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RX_IDLE = 1'b0, RX_ACK = 1'b1} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_SEND = 2'd1, TX_WAIT = 2'd2} tx_state_t;

  rx_state_t rx_q, rx_d;
  tx_state_t tx_q, tx_d;

  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]    rx_wr, rx_rd, tx_wr, tx_rd;
  logic [CW-1:0]    rx_cnt, tx_cnt;
  logic [WIDTH-1:0] out_q;
  logic             rx_store, rx_pop, tx_push, tx_pop;

  // Handshakes: a producer word transfers when inDataReady=1 meets RX_IDLE with
  // registered room; inACK then follows inDataReady down. A consumer word is
  // offered with outDataReady=1 until outACK=1, and the next word waits for outACK=0.
  always_comb begin
    rx_d     = rx_q;
    rx_store = 1'b0;
    case (rx_q)
      RX_IDLE: if (bus.inDataReady && rx_cnt != FULL) begin
        rx_store = 1'b1;
        rx_d     = RX_ACK;
      end
      RX_ACK:  if (!bus.inDataReady) rx_d = RX_IDLE;
      default: rx_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_d   = tx_q;
    tx_pop = 1'b0;
    case (tx_q)
      TX_IDLE: if (tx_cnt != '0 && !bus.outACK) begin
        tx_pop = 1'b1;
        tx_d   = TX_SEND;
      end
      TX_SEND: if (bus.outACK) tx_d = TX_WAIT;
      TX_WAIT: if (!bus.outACK) tx_d = TX_IDLE;
      default: tx_d = TX_IDLE;
    endcase
  end

  assign rx_pop  = bus.rxRead && rx_cnt != '0;
  assign tx_push = bus.txWrite && tx_cnt != FULL;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_q   <= RX_IDLE;
      tx_q   <= TX_IDLE;
      rx_wr  <= '0;
      rx_rd  <= '0;
      tx_wr  <= '0;
      tx_rd  <= '0;
      rx_cnt <= '0;
      tx_cnt <= '0;
      out_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rx_mem[i] <= '0;
        tx_mem[i] <= '0;
      end
    end else begin
      rx_q <= rx_d;
      tx_q <= tx_d;
      if (rx_store) begin
        rx_mem[rx_wr] <= bus.in;
        rx_wr         <= rx_wr + AW'(1);
      end
      if (rx_pop) rx_rd <= rx_rd + AW'(1);
      // Store and pop in the same cycle leave the occupancy untouched.
      case ({rx_store, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      if (tx_push) begin
        tx_mem[tx_wr] <= bus.txData;
        tx_wr         <= tx_wr + AW'(1);
      end
      if (tx_pop) begin
        out_q <= tx_mem[tx_rd];
        tx_rd <= tx_rd + AW'(1);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  assign bus.inACK        = (rx_q == RX_ACK);
  assign bus.outDataReady = (tx_q == TX_SEND);
  assign bus.out          = out_q;
  assign bus.rxData       = rx_mem[rx_rd];
  assign bus.rxEmpty      = (rx_cnt == '0);
  assign bus.rxCount      = rx_cnt;
  assign bus.txFull       = (tx_cnt == FULL);
  assign bus.txCount      = tx_cnt;
  assign rx_state         = rx_q;
  assign tx_state         = tx_q;
endmodule
